wasm_operand_stack: RTL and testbench
=====================================

# wasm_operand_stack

Parametrised operand stack for the WASM execution pipeline: pops up to `WIN` operands and pushes up to `MAX_PUSH` results per cycle, and tracks structured-control frames (block/loop/call) so a branch or `end` can unwind to the frame base in one cycle. It sits between the decoder/ALU stage and the register/ALU datapath. Over/underflow is detected before commit, rejected atomically, and latched as a sticky trap for the control unit.

## Interface
Parameters:
- `DATA_W`, 32, operand width (i32; 64 for i64 builds)
- `DEPTH`, 16, operand entries; power of two, ≥ 4
- `WIN`, 3, pop-window count and max `pop_num`
- `MAX_PUSH`, 2, max `push_num` and max `keep_num`
- `FRAMES`, 8, frame-base stack entries; power of two

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `op_valid`  in  1  operation this cycle
- `op_kind`  in  2  0 ALU, 1 ENTER, 2 EXIT, 3 illegal
- `pop_num`  in  clog2(WIN+1)  entries popped (ALU) / frame params (ENTER)
- `push_num`  in  clog2(MAX_PUSH+1)  entries pushed (ALU)
- `keep_num`  in  clog2(MAX_PUSH+1)  results kept on EXIT
- `push_data`  in  DATA_W*MAX_PUSH  slot 0 = LSBs = pushed first (deeper)
- `win_data`  out  DATA_W*WIN  slot i = entry at depth-1-i
- `win_valid`  out  WIN  bit i = depth > i
- `depth`  out  clog2(DEPTH)+1  current entry count
- `frame_depth`  out  clog2(FRAMES)+1  open frames
- `trap`  out  1  sticky error
- `trap_code`  out  3  1 underflow, 2 overflow, 3 frame overflow, 4 frame underflow, 5 illegal op
- `trap_clr`  in  1  clears `trap`/`trap_code`

## Operation
- ALU: check `pop_num ≤ depth` (else underflow) and `depth − pop_num + push_num ≤ DEPTH` (else overflow); on pass, write push slots at `depth−pop_num+k`, k < push_num; `depth ← depth − pop_num + push_num`.
- ENTER: base = `depth − pop_num` (params belong to new frame); underflow if `pop_num > depth`, frame overflow if `frame_depth == FRAMES`; else push base on frame stack.
- EXIT: frame underflow if `frame_depth == 0`; underflow if `depth − base < keep_num`; else copy top `keep_num` entries to `base..base+keep_num−1` (order preserved), `depth ← base + keep_num`, pop frame stack.
- Any failing check: no state change except trap; first error wins (`trap_code` holds first cause until `trap_clr`). While `trap` is set every `op_valid` is ignored.
- Priority: illegal op > frame checks > operand underflow > overflow.
- `win_data` slot i reads 0 when `win_valid[i]` = 0 (never Z).
- `trap_clr` with a simultaneous op: clear applies, op is ignored that cycle.

## Timing
- Reset: `depth`=0, `frame_depth`=0, `trap`=0, `trap_code`=0, `win_valid`=0, `win_data`=0; memory contents undefined, not reset.
- Windows/`depth`/`frame_depth` combinational from registered state; op committed at clock edge N is visible after edge N; 0-cycle read, 1-cycle write.
- No back-pressure; one op per cycle sustained.
- `trap` rises the edge after the failing op. Reset mid-op discards it.
- Exactly full (`depth == DEPTH`) is legal; pop-then-push at full with net ≤ 0 is legal.

## Structure
- Package `wasm_stack_pkg`: `op_kind` encodings, `trap_code` constants, `clog2` width helpers; shared with decoder/control.
- Sub-module `wasm_frame_stack` (FRAMES×(clog2(DEPTH)+1) LIFO with push/pop/top/full/empty); operand storage, checks and EXIT copy stay in the top level.

## Test plan
- Reset, ALU push 2 (0xA,0xB) -> depth 2, win_data slot0=0xB, slot1=0xA, win_valid=0b011, slot2=0.
- depth 3 [1,2,3], ALU pop 2 push 1 (0x5) -> depth 2, slot0=0x5, slot1=1.
- Fill to 16, ALU push 1 -> trap=1, code 2, depth stays 16; next ops ignored until trap_clr.
- depth 0, ALU pop 1 -> trap code 1; with illegal op_kind=3 same cycle -> code 5.
- depth 2, ENTER pop 1, push 3 values (0x7,0x8,0x9), EXIT keep 1 -> depth 2, slot0=0x9, frame_depth 0.
- 8 ENTERs then ENTER -> code 3; EXIT at frame_depth 0 -> code 4.

Source files
------------

// File: rtl/wasm_stack_pkg.sv
// Shared encodings and width helpers for the WASM operand stack and its clients.
package wasm_stack_pkg;

    typedef enum logic [1:0] {
        OP_ALU     = 2'd0,
        OP_ENTER   = 2'd1,
        OP_EXIT    = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_kind_e;

    typedef enum logic [2:0] {
        TRAP_NONE      = 3'd0,
        TRAP_UNDERFLOW = 3'd1,
        TRAP_OVERFLOW  = 3'd2,
        TRAP_FRAME_OVF = 3'd3,
        TRAP_FRAME_UNF = 3'd4,
        TRAP_ILLEGAL   = 3'd5
    } trap_code_e;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/wasm_frame_stack.sv
// LIFO of frame base pointers; one entry per open block/loop/call frame.
module wasm_frame_stack #(
    parameter int FRAMES  = 8,
    parameter int ENTRY_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [ENTRY_W-1:0]        push_data,
    output logic [ENTRY_W-1:0]        top,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(FRAMES):0]   count
);
    localparam int AW = $clog2(FRAMES);
    localparam int CW = AW + 1;

    logic [ENTRY_W-1:0] mem [FRAMES];
    logic [CW-1:0]      count_q;

    assign full  = (count_q == CW'(FRAMES));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign top   = empty ? '0 : mem[AW'(count_q - CW'(1))];

    // Frame base storage; contents are not reset, only the count is.
    always_ff @(posedge clk) begin
        if (push && !full) mem[count_q[AW-1:0]] <= push_data;
    end

    // Occupancy count; the caller never pushes and pops in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               count_q <= '0;
        else if (push && !full)   count_q <= count_q + CW'(1);
        else if (pop && !empty)   count_q <= count_q - CW'(1);
    end

endmodule

// File: rtl/wasm_operand_stack.sv
// Operand stack with pop window, multi-push, frame unwinding and a sticky trap.
module wasm_operand_stack
    import wasm_stack_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int WIN      = 3,
    parameter int MAX_PUSH = 2,
    parameter int FRAMES   = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               op_valid,
    input  logic [1:0]                         op_kind,
    input  logic [$clog2(WIN+1)-1:0]           pop_num,
    input  logic [$clog2(MAX_PUSH+1)-1:0]      push_num,
    input  logic [$clog2(MAX_PUSH+1)-1:0]      keep_num,
    input  logic [DATA_W*MAX_PUSH-1:0]         push_data,
    output logic [DATA_W*WIN-1:0]              win_data,
    output logic [WIN-1:0]                     win_valid,
    output logic [$clog2(DEPTH):0]             depth,
    output logic [$clog2(FRAMES):0]            frame_depth,
    output logic                               trap,
    output logic [2:0]                         trap_code,
    input  logic                               trap_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = count_w(DEPTH);
    localparam int XW = DW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DW-1:0]     depth_q;
    logic              trap_q;
    trap_code_e        code_q;

    logic [DW-1:0]     frame_top;
    logic              frame_full, frame_empty, frame_push, frame_pop;

    logic [XW-1:0]     depth_x, pop_x, push_x, keep_x, base_x, after_pop_x, after_push_x;
    op_kind_e          kind;
    trap_code_e        err;
    logic              accept, commit;
    logic [DW-1:0]     depth_next;

    logic [MAX_PUSH-1:0] wr_en;
    logic [AW-1:0]       wr_addr [MAX_PUSH];
    logic [DATA_W-1:0]   wr_data [MAX_PUSH];

    assign kind         = op_kind_e'(op_kind);
    assign depth_x      = XW'(depth_q);
    assign pop_x        = XW'(pop_num);
    assign push_x       = XW'(push_num);
    assign keep_x       = XW'(keep_num);
    assign base_x       = XW'(frame_top);
    assign after_pop_x  = depth_x - pop_x;
    assign after_push_x = after_pop_x + push_x;

    assign accept     = op_valid && !trap_q && !trap_clr;
    assign commit     = accept && (err == TRAP_NONE);
    assign frame_push = commit && (kind == OP_ENTER);
    assign frame_pop  = commit && (kind == OP_EXIT);

    assign depth     = depth_q;
    assign trap      = trap_q;
    assign trap_code = code_q;

    wasm_frame_stack #(
        .FRAMES  (FRAMES),
        .ENTRY_W (DW)
    ) u_frames (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (frame_push),
        .pop       (frame_pop),
        .push_data (DW'(after_pop_x)),
        .top       (frame_top),
        .full      (frame_full),
        .empty     (frame_empty),
        .count     (frame_depth)
    );

    // Pre-commit checks in priority order: illegal, frame, underflow, overflow.
    always_comb begin
        err = TRAP_NONE;
        case (kind)
            OP_ALU: begin
                if (pop_x > depth_x)                 err = TRAP_UNDERFLOW;
                else if (after_push_x > XW'(DEPTH))  err = TRAP_OVERFLOW;
            end
            OP_ENTER: begin
                if (frame_full)                      err = TRAP_FRAME_OVF;
                else if (pop_x > depth_x)            err = TRAP_UNDERFLOW;
            end
            OP_EXIT: begin
                if (frame_empty)                     err = TRAP_FRAME_UNF;
                else if (depth_x < base_x + keep_x)  err = TRAP_UNDERFLOW;
            end
            default:                                 err = TRAP_ILLEGAL;
        endcase
    end

    // Write ports: ALU pushes land above the popped region, EXIT slides kept results down to the base.
    always_comb begin
        for (int k = 0; k < MAX_PUSH; k++) begin
            wr_en[k]   = 1'b0;
            wr_addr[k] = '0;
            wr_data[k] = '0;
            if (commit && kind == OP_ALU && k < int'(push_num)) begin
                wr_en[k]   = 1'b1;
                wr_addr[k] = AW'(after_pop_x + XW'(k));
                wr_data[k] = push_data[k*DATA_W +: DATA_W];
            end else if (commit && kind == OP_EXIT && k < int'(keep_num)) begin
                wr_en[k]   = 1'b1;
                wr_addr[k] = AW'(base_x + XW'(k));
                wr_data[k] = mem[AW'(depth_x - keep_x + XW'(k))];
            end
        end
    end

    // Depth after a successful op.
    always_comb begin
        depth_next = depth_q;
        case (kind)
            OP_ALU:  depth_next = DW'(after_push_x);
            OP_EXIT: depth_next = DW'(base_x + keep_x);
            default: depth_next = depth_q;
        endcase
    end

    // Operand storage; not reset, only written by committed ops.
    always_ff @(posedge clk) begin
        for (int k = 0; k < MAX_PUSH; k++) begin
            if (wr_en[k]) mem[wr_addr[k]] <= wr_data[k];
        end
    end

    // Depth and sticky trap; a clear wins over any op in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            trap_q  <= 1'b0;
            code_q  <= TRAP_NONE;
        end else if (trap_clr) begin
            trap_q <= 1'b0;
            code_q <= TRAP_NONE;
        end else if (accept) begin
            if (err != TRAP_NONE) begin
                trap_q <= 1'b1;
                code_q <= err;
            end else begin
                depth_q <= depth_next;
            end
        end
    end

    // Read window: slot i is the entry at depth-1-i, zero when absent.
    always_comb begin
        for (int i = 0; i < WIN; i++) begin
            win_valid[i] = depth_x > XW'(i);
            win_data[i*DATA_W +: DATA_W] = win_valid[i] ? mem[AW'(depth_x - XW'(1) - XW'(i))] : '0;
        end
    end

endmodule

// File: tb/tb_wasm_operand_stack.sv
// Directed self-checking bench for wasm_operand_stack.
module tb_wasm_operand_stack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_kind = 2'd0;
    logic [1:0]  pop_num = 2'd0;
    logic [1:0]  push_num = 2'd0;
    logic [1:0]  keep_num = 2'd0;
    logic [63:0] push_data = '0;
    logic [95:0] win_data;
    logic [2:0]  win_valid;
    logic [4:0]  depth;
    logic [3:0]  frame_depth;
    logic        trap;
    logic [2:0]  trap_code;
    logic        trap_clr = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    wasm_operand_stack dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_kind     (op_kind),
        .pop_num     (pop_num),
        .push_num    (push_num),
        .keep_num    (keep_num),
        .push_data   (push_data),
        .win_data    (win_data),
        .win_valid   (win_valid),
        .depth       (depth),
        .frame_depth (frame_depth),
        .trap        (trap),
        .trap_code   (trap_code),
        .trap_clr    (trap_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] slot(input int i);
        return win_data[i*32 +: 32];
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; op_valid = 1'b0; trap_clr = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_op(input logic [1:0] kind, input logic [1:0] pop, input logic [1:0] push,
                         input logic [1:0] keep, input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clk);
        op_valid = 1'b1; op_kind = kind; pop_num = pop; push_num = push; keep_num = keep;
        push_data = {d1, d0};
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic clear_trap_with_op();
        @(negedge clk);
        trap_clr = 1'b1; op_valid = 1'b1; op_kind = 2'd0; pop_num = 2'd1; push_num = 2'd0;
        @(posedge clk);
        #1;
        trap_clr = 1'b0; op_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_cmp++; if (depth !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_depth got %0d want 0", depth); end
        n_cmp++; if (frame_depth !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_frame_depth got %0d want 0", frame_depth); end
        n_cmp++; if (trap !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_trap got %b want 0", trap); end
        n_cmp++; if (trap_code !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_code got %0d want 0", trap_code); end
        n_cmp++; if (win_valid !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_win_valid got %b want 000", win_valid); end
        n_cmp++; if (win_data !== 96'd0) begin n_fail++; $display("[TB] FAIL reset_win_data got %h want 0", win_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_push();
        apply_reset();
        do_op(2'd0, 2'd0, 2'd2, 2'd0, 32'hA, 32'hB);
        n_cmp++; if (depth !== 5'd2) begin n_fail++; $display("[TB] FAIL push_depth got %0d want 2", depth); end
        n_cmp++; if (slot(0) !== 32'hB) begin n_fail++; $display("[TB] FAIL push_slot0 got %h want b", slot(0)); end
        n_cmp++; if (slot(1) !== 32'hA) begin n_fail++; $display("[TB] FAIL push_slot1 got %h want a", slot(1)); end
        n_cmp++; if (win_valid !== 3'b011) begin n_fail++; $display("[TB] FAIL push_win_valid got %b want 011", win_valid); end
        n_cmp++; if (slot(2) !== 32'h0) begin n_fail++; $display("[TB] FAIL push_slot2 got %h want 0", slot(2)); end
    endtask

    task automatic test_pop_push();
        apply_reset();
        do_op(2'd0, 2'd0, 2'd2, 2'd0, 32'h1, 32'h2);
        do_op(2'd0, 2'd0, 2'd1, 2'd0, 32'h3, 32'h0);
        n_cmp++; if (slot(0) !== 32'h3) begin n_fail++; $display("[TB] FAIL three_top got %h want 3", slot(0)); end
        do_op(2'd0, 2'd2, 2'd1, 2'd0, 32'h5, 32'h0);
        n_cmp++; if (depth !== 5'd2) begin n_fail++; $display("[TB] FAIL poppush_depth got %0d want 2", depth); end
        n_cmp++; if (slot(0) !== 32'h5) begin n_fail++; $display("[TB] FAIL poppush_slot0 got %h want 5", slot(0)); end
        n_cmp++; if (slot(1) !== 32'h1) begin n_fail++; $display("[TB] FAIL poppush_slot1 got %h want 1", slot(1)); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int k = 0; k < 8; k++) do_op(2'd0, 2'd0, 2'd2, 2'd0, 32'(2*k), 32'(2*k+1));
        n_cmp++; if (depth !== 5'd16) begin n_fail++; $display("[TB] FAIL full_depth got %0d want 16", depth); end
        n_cmp++; if (trap !== 1'b0) begin n_fail++; $display("[TB] FAIL full_no_trap got %b want 0", trap); end
        n_cmp++; if (slot(0) !== 32'd15) begin n_fail++; $display("[TB] FAIL full_slot0 got %h want f", slot(0)); end
        do_op(2'd0, 2'd0, 2'd1, 2'd0, 32'h99, 32'h0);
        n_cmp++; if (trap !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_trap got %b want 1", trap); end
        n_cmp++; if (trap_code !== 3'd2) begin n_fail++; $display("[TB] FAIL ovf_code got %0d want 2", trap_code); end
        n_cmp++; if (depth !== 5'd16) begin n_fail++; $display("[TB] FAIL ovf_depth got %0d want 16", depth); end
        n_cmp++; if (slot(0) !== 32'd15) begin n_fail++; $display("[TB] FAIL ovf_slot0 got %h want f", slot(0)); end
        do_op(2'd0, 2'd1, 2'd0, 2'd0, 32'h0, 32'h0);
        do_op(2'd3, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0);
        n_cmp++; if (depth !== 5'd16) begin n_fail++; $display("[TB] FAIL trapped_ignore_depth got %0d want 16", depth); end
        n_cmp++; if (trap_code !== 3'd2) begin n_fail++; $display("[TB] FAIL first_error_wins got %0d want 2", trap_code); end
        clear_trap_with_op();
        n_cmp++; if (trap !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_trap got %b want 0", trap); end
        n_cmp++; if (trap_code !== 3'd0) begin n_fail++; $display("[TB] FAIL clr_code got %0d want 0", trap_code); end
        n_cmp++; if (depth !== 5'd16) begin n_fail++; $display("[TB] FAIL clr_op_ignored got %0d want 16", depth); end
        do_op(2'd0, 2'd1, 2'd1, 2'd0, 32'h77, 32'h0);
        n_cmp++; if (depth !== 5'd16) begin n_fail++; $display("[TB] FAIL full_net0_depth got %0d want 16", depth); end
        n_cmp++; if (trap !== 1'b0) begin n_fail++; $display("[TB] FAIL full_net0_trap got %b want 0", trap); end
        n_cmp++; if (slot(0) !== 32'h77) begin n_fail++; $display("[TB] FAIL full_net0_slot0 got %h want 77", slot(0)); end
        n_cmp++; if (slot(1) !== 32'd14) begin n_fail++; $display("[TB] FAIL full_net0_slot1 got %h want e", slot(1)); end
    endtask

    task automatic test_underflow();
        apply_reset();
        do_op(2'd0, 2'd1, 2'd0, 2'd0, 32'h0, 32'h0);
        n_cmp++; if (trap_code !== 3'd1) begin n_fail++; $display("[TB] FAIL unf_code got %0d want 1", trap_code); end
        n_cmp++; if (depth !== 5'd0) begin n_fail++; $display("[TB] FAIL unf_depth got %0d want 0", depth); end
        clear_trap_with_op();
        do_op(2'd3, 2'd1, 2'd0, 2'd0, 32'h0, 32'h0);
        n_cmp++; if (trap_code !== 3'd5) begin n_fail++; $display("[TB] FAIL illegal_code got %0d want 5", trap_code); end
        n_cmp++; if (trap !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal_trap got %b want 1", trap); end
    endtask

    task automatic test_frame_exit();
        apply_reset();
        do_op(2'd0, 2'd0, 2'd2, 2'd0, 32'h1, 32'h2);
        do_op(2'd1, 2'd1, 2'd0, 2'd0, 32'h0, 32'h0);
        n_cmp++; if (frame_depth !== 4'd1) begin n_fail++; $display("[TB] FAIL enter_frame_depth got %0d want 1", frame_depth); end
        n_cmp++; if (depth !== 5'd2) begin n_fail++; $display("[TB] FAIL enter_depth got %0d want 2", depth); end
        do_op(2'd0, 2'd0, 2'd2, 2'd0, 32'h7, 32'h8);
        do_op(2'd0, 2'd0, 2'd1, 2'd0, 32'h9, 32'h0);
        n_cmp++; if (depth !== 5'd5) begin n_fail++; $display("[TB] FAIL body_depth got %0d want 5", depth); end
        do_op(2'd2, 2'd0, 2'd0, 2'd1, 32'h0, 32'h0);
        n_cmp++; if (depth !== 5'd2) begin n_fail++; $display("[TB] FAIL exit_depth got %0d want 2", depth); end
        n_cmp++; if (slot(0) !== 32'h9) begin n_fail++; $display("[TB] FAIL exit_slot0 got %h want 9", slot(0)); end
        n_cmp++; if (slot(1) !== 32'h1) begin n_fail++; $display("[TB] FAIL exit_slot1 got %h want 1", slot(1)); end
        n_cmp++; if (frame_depth !== 4'd0) begin n_fail++; $display("[TB] FAIL exit_frame_depth got %0d want 0", frame_depth); end
        n_cmp++; if (trap !== 1'b0) begin n_fail++; $display("[TB] FAIL exit_trap got %b want 0", trap); end
    endtask

    task automatic test_exit_keep2();
        apply_reset();
        do_op(2'd0, 2'd0, 2'd2, 2'd0, 32'h10, 32'h11);
        do_op(2'd1, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0);
        do_op(2'd0, 2'd0, 2'd2, 2'd0, 32'h20, 32'h21);
        do_op(2'd0, 2'd0, 2'd1, 2'd0, 32'h22, 32'h0);
        do_op(2'd2, 2'd0, 2'd0, 2'd2, 32'h0, 32'h0);
        n_cmp++; if (depth !== 5'd4) begin n_fail++; $display("[TB] FAIL keep2_depth got %0d want 4", depth); end
        n_cmp++; if (slot(0) !== 32'h22) begin n_fail++; $display("[TB] FAIL keep2_slot0 got %h want 22", slot(0)); end
        n_cmp++; if (slot(1) !== 32'h21) begin n_fail++; $display("[TB] FAIL keep2_slot1 got %h want 21", slot(1)); end
        n_cmp++; if (slot(2) !== 32'h11) begin n_fail++; $display("[TB] FAIL keep2_slot2 got %h want 11", slot(2)); end
    endtask

    task automatic test_frame_limits();
        apply_reset();
        for (int k = 0; k < 8; k++) do_op(2'd1, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0);
        n_cmp++; if (frame_depth !== 4'd8) begin n_fail++; $display("[TB] FAIL frames_full got %0d want 8", frame_depth); end
        n_cmp++; if (trap !== 1'b0) begin n_fail++; $display("[TB] FAIL frames_full_trap got %b want 0", trap); end
        do_op(2'd1, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0);
        n_cmp++; if (trap_code !== 3'd3) begin n_fail++; $display("[TB] FAIL frame_ovf_code got %0d want 3", trap_code); end
        n_cmp++; if (frame_depth !== 4'd8) begin n_fail++; $display("[TB] FAIL frame_ovf_depth got %0d want 8", frame_depth); end
        clear_trap_with_op();
        for (int k = 0; k < 8; k++) do_op(2'd2, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0);
        n_cmp++; if (frame_depth !== 4'd0) begin n_fail++; $display("[TB] FAIL frames_empty got %0d want 0", frame_depth); end
        do_op(2'd2, 2'd0, 2'd0, 2'd1, 32'h0, 32'h0);
        n_cmp++; if (trap_code !== 3'd4) begin n_fail++; $display("[TB] FAIL frame_unf_code got %0d want 4", trap_code); end
        n_cmp++; if (trap !== 1'b1) begin n_fail++; $display("[TB] FAIL frame_unf_trap got %b want 1", trap); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_op(2'd0, 2'd0, 2'd2, 2'd0, 32'hA1, 32'hB1);
        do_op(2'd0, 2'd0, 2'd1, 2'd0, 32'hC1, 32'h0);
        do_op(2'd0, 2'd2, 2'd1, 2'd0, 32'hD1, 32'h0);
        n_cmp++; if (depth !== 5'd2) begin n_fail++; $display("[TB] FAIL b2b_depth got %0d want 2", depth); end
        n_cmp++; if (slot(0) !== 32'hD1) begin n_fail++; $display("[TB] FAIL b2b_slot0 got %h want d1", slot(0)); end
        n_cmp++; if (slot(1) !== 32'hA1) begin n_fail++; $display("[TB] FAIL b2b_slot1 got %h want a1", slot(1)); end
        n_cmp++; if (win_valid !== 3'b011) begin n_fail++; $display("[TB] FAIL b2b_win_valid got %b want 011", win_valid); end
    endtask

    initial begin
        $display("[TB] starting wasm_operand_stack bench");
        test_reset();
        test_alu_push();
        test_pop_push();
        test_overflow();
        test_underflow();
        test_frame_exit();
        test_exit_keep2();
        test_frame_limits();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
